io_sw_conditioner: RTL and testbench

//  Input-side conditioner for the i_io_sw switch bank: synchronises raw switch levels into i_clk,

---
 rtl/io_sw_conditioner.sv | 102 ++++++++++
 tb/tb_io_sw_conditioner.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_sw_conditioner.sv
// Switch-bank input conditioner: synchronise, per-bit debounce, edge pulses and sticky pending flags.
// Bits are independent; the only shared state is the prescaler tick.
module io_sw_conditioner #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TICK_DIV       = 1,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_raw,
  input  logic [WIDTH-1:0] i_evt_clr,
  output logic [WIDTH-1:0] o_sw_stable,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic [WIDTH-1:0] o_evt_pending,
  output logic             o_evt_any
);

  localparam int unsigned CW      = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic             tick;
  logic [CW-1:0]    cnt_r   [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] toggle_c;

  // Synchroniser chain; only the last stage feeds the debouncer.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
    end else begin
      sync_r[0] <= i_sw_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // Free-running prescaler; tick is asserted while the count sits at its top value.
  generate
    if (TICK_DIV == 1) begin : g_tick_always
      assign tick = 1'b1;
    end else begin : g_tick_div
      localparam int unsigned DW = $clog2(TICK_DIV);
      localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
      logic [DW-1:0] div_r;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          div_r <= '0;
        end else if (div_r == DIV_MAX) begin
          div_r <= '0;
        end else begin
          div_r <= div_r + DW'(1);
        end
      end

      assign tick = (div_r == DIV_MAX);
    end
  endgenerate

  // Per-bit debounce counter: any agreement clears it, DEBOUNCE_TICKS disagreeing ticks flip the bit.
  always_comb begin
    toggle_c = '0;
    cnt_nxt  = cnt_r;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync_q[i] == o_sw_stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt_r[i] == CNT_MAX) begin
          toggle_c[i] = 1'b1;
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Outputs; pending is set from the registered pulses so a same-cycle clear never drops an event.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_r[i] <= '0;
      o_sw_stable   <= '0;
      o_sw_rise     <= '0;
      o_sw_fall     <= '0;
      o_evt_pending <= '0;
      o_evt_any     <= 1'b0;
    end else begin
      cnt_r         <= cnt_nxt;
      o_sw_stable   <= o_sw_stable ^ toggle_c;
      o_sw_rise     <= toggle_c & ~o_sw_stable;
      o_sw_fall     <= toggle_c & o_sw_stable;
      o_evt_pending <= (o_evt_pending & ~i_evt_clr) | o_sw_rise | o_sw_fall;
      o_evt_any     <= |o_evt_pending;
    end
  end

endmodule

// File: tb/tb_io_sw_conditioner.sv
// Bench for io_sw_conditioner: sliding-window reference model for the default build,
// directed timing checks for a prescaled build.
module tb_io_sw_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DB   = 4;
  localparam int unsigned HM   = SYNC + DB - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sw_raw, evt_clr;
  logic [31:0] sw_stable, sw_rise, sw_fall, evt_pending;
  logic        evt_any;

  logic        rst_t;
  logic [31:0] raw_t, clr_t;
  logic [31:0] stable_t, rise_t, fall_t, pend_t;
  logic        any_t;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  io_sw_conditioner dut (
    .i_clk(clk), .i_reset(rst_n), .i_sw_raw(sw_raw), .i_evt_clr(evt_clr),
    .o_sw_stable(sw_stable), .o_sw_rise(sw_rise), .o_sw_fall(sw_fall),
    .o_evt_pending(evt_pending), .o_evt_any(evt_any)
  );

  io_sw_conditioner #(.WIDTH(32), .SYNC_STAGES(2), .TICK_DIV(4), .DEBOUNCE_TICKS(2)) dut_t (
    .i_clk(clk), .i_reset(rst_t), .i_sw_raw(raw_t), .i_evt_clr(clr_t),
    .o_sw_stable(stable_t), .o_sw_rise(rise_t), .o_sw_fall(fall_t),
    .o_evt_pending(pend_t), .o_evt_any(any_t)
  );

  // Reference model: a bit flips once its last DB synchronised samples all disagree with it.
  // hist[j] holds the raw value sampled j+1 edges ago.
  logic [31:0] hist [HM];
  logic [31:0] m_stable, m_rise, m_fall, m_pend;
  logic        m_any;

  function automatic logic [31:0] flip_of(input logic [31:0] st);
    logic [31:0] f;
    f = '1;
    for (int j = SYNC - 1; j < HM; j++) f &= hist[j] ^ st;
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < HM; j++) hist[j] <= '0;
      m_stable <= '0; m_rise <= '0; m_fall <= '0; m_pend <= '0; m_any <= 1'b0;
    end else begin
      m_any    <= |m_pend;
      m_pend   <= (m_pend & ~evt_clr) | m_rise | m_fall;
      m_rise   <= flip_of(m_stable) & ~m_stable;
      m_fall   <= flip_of(m_stable) & m_stable;
      m_stable <= m_stable ^ flip_of(m_stable);
      hist[0]  <= sw_raw;
      for (int j = 1; j < HM; j++) hist[j] <= hist[j-1];
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; rst_t = 1'b0; sw_raw = 32'h0000_00A5; evt_clr = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({sw_stable, sw_rise, sw_fall, evt_pending, evt_any} !== '0) begin
      miscompares++;
      $display("FAIL reset_zero: got stable=%h rise=%h fall=%h pend=%h any=%b, want all 0",
               sw_stable, sw_rise, sw_fall, evt_pending, evt_any);
    end
    rst_n = 1'b1; rst_t = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      vectors++;
      if ({sw_stable, sw_rise, sw_fall, evt_pending, evt_any} !== {m_stable, m_rise, m_fall, m_pend, m_any}) begin
        miscompares++;
        $display("FAIL reset_model n=%0d: got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", n,
                 sw_stable, sw_rise, sw_fall, evt_pending, evt_any, m_stable, m_rise, m_fall, m_pend, m_any);
      end
      if (n == 5) begin
        vectors++;
        if (sw_stable !== 32'h0) begin miscompares++; $display("FAIL reset_edge5_stable: got %h want 00000000", sw_stable); end
      end
      if (n == 6) begin
        vectors++;
        if (sw_stable !== 32'hA5 || sw_rise !== 32'hA5) begin
          miscompares++; $display("FAIL reset_edge6: got stable=%h rise=%h want both 000000a5", sw_stable, sw_rise);
        end
      end
      if (n == 7) begin
        vectors++;
        if (evt_pending !== 32'hA5 || sw_rise !== 32'h0 || evt_any !== 1'b0) begin
          miscompares++; $display("FAIL reset_edge7: got pend=%h rise=%h any=%b want 000000a5/0/0", evt_pending, sw_rise, evt_any);
        end
      end
      if (n == 8) begin
        vectors++;
        if (evt_any !== 1'b1) begin miscompares++; $display("FAIL reset_edge8_any: got %b want 1", evt_any); end
      end
    end
  endtask

  task automatic test_glitch();
    evt_clr = '1;
    @(negedge clk);
    evt_clr = '0;
    sw_raw  = 32'hA5 | 32'h8;
    repeat (3) @(negedge clk);
    sw_raw = 32'hA5;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      vectors++;
      if ({sw_stable, sw_rise, sw_fall, evt_pending, evt_any} !== {m_stable, m_rise, m_fall, m_pend, m_any}) begin
        miscompares++;
        $display("FAIL glitch_model n=%0d: got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", n,
                 sw_stable, sw_rise, sw_fall, evt_pending, evt_any, m_stable, m_rise, m_fall, m_pend, m_any);
      end
    end
    vectors++;
    if (sw_stable !== 32'hA5 || evt_pending !== 32'h0) begin
      miscompares++; $display("FAIL glitch_filtered: got stable=%h pend=%h want 000000a5/00000000", sw_stable, evt_pending);
    end
  endtask

  task automatic test_fall_bounce();
    sw_raw = 32'hA4;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      vectors++;
      if ({sw_stable, sw_rise, sw_fall, evt_pending, evt_any} !== {m_stable, m_rise, m_fall, m_pend, m_any}) begin
        miscompares++;
        $display("FAIL fall_model n=%0d: got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", n,
                 sw_stable, sw_rise, sw_fall, evt_pending, evt_any, m_stable, m_rise, m_fall, m_pend, m_any);
      end
      if (n == 5) begin
        vectors++;
        if (sw_stable !== 32'hA5) begin miscompares++; $display("FAIL fall_early: got stable=%h want 000000a5", sw_stable); end
      end
      if (n == 6) begin
        vectors++;
        if (sw_fall !== 32'h1 || sw_stable !== 32'hA4) begin
          miscompares++; $display("FAIL fall_edge6: got fall=%h stable=%h want 00000001/000000a4", sw_fall, sw_stable);
        end
      end
    end
    sw_raw = 32'hA5;
    repeat (8) @(negedge clk);
    // Bounce 0,1 then settle at 0: the settled level is first sampled at edge 3.
    sw_raw = 32'hA4;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) sw_raw = 32'hA5;
      if (n == 2) sw_raw = 32'hA4;
      vectors++;
      if ({sw_stable, sw_rise, sw_fall, evt_pending, evt_any} !== {m_stable, m_rise, m_fall, m_pend, m_any}) begin
        miscompares++;
        $display("FAIL bounce_model n=%0d: got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", n,
                 sw_stable, sw_rise, sw_fall, evt_pending, evt_any, m_stable, m_rise, m_fall, m_pend, m_any);
      end
      if (n == 7) begin
        vectors++;
        if (sw_stable[0] !== 1'b1) begin miscompares++; $display("FAIL bounce_early: got stable[0]=%b want 1", sw_stable[0]); end
      end
      if (n == 8) begin
        vectors++;
        if (sw_fall !== 32'h1) begin miscompares++; $display("FAIL bounce_fall: got fall=%h want 00000001", sw_fall); end
      end
    end
  endtask

  task automatic test_clear_collision();
    evt_clr = ~32'h1;
    @(negedge clk);
    evt_clr = '0;
    @(negedge clk);
    vectors++;
    if (evt_pending !== 32'h1) begin miscompares++; $display("FAIL clr_pre_pend: got %h want 00000001", evt_pending); end
    sw_raw = 32'hA5;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      vectors++;
      if ({sw_stable, sw_rise, sw_fall, evt_pending, evt_any} !== {m_stable, m_rise, m_fall, m_pend, m_any}) begin
        miscompares++;
        $display("FAIL clr_model n=%0d: got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", n,
                 sw_stable, sw_rise, sw_fall, evt_pending, evt_any, m_stable, m_rise, m_fall, m_pend, m_any);
      end
      if (n == 6) begin
        vectors++;
        if (sw_rise !== 32'h1) begin miscompares++; $display("FAIL clr_rise: got %h want 00000001", sw_rise); end
        evt_clr = 32'h1;
      end
      if (n == 7) begin
        vectors++;
        if (evt_pending !== 32'h1) begin miscompares++; $display("FAIL clr_set_wins: got pend=%h want 00000001", evt_pending); end
      end
      if (n == 8) begin
        vectors++;
        if (evt_pending !== 32'h0 || evt_any !== 1'b1) begin
          miscompares++; $display("FAIL clr_cleared: got pend=%h any=%b want 00000000/1", evt_pending, evt_any);
        end
        evt_clr = '0;
      end
      if (n == 9) begin
        vectors++;
        if (evt_any !== 1'b0) begin miscompares++; $display("FAIL clr_any_low: got %b want 0", evt_any); end
      end
    end
  endtask

  task automatic test_all_bits();
    sw_raw = '0;
    repeat (8) @(negedge clk);
    for (int phase = 0; phase < 2; phase++) begin
      sw_raw = (phase == 0) ? 32'hFFFF_FFFF : 32'h0;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        vectors++;
        if ({sw_stable, sw_rise, sw_fall, evt_pending, evt_any} !== {m_stable, m_rise, m_fall, m_pend, m_any}) begin
          miscompares++;
          $display("FAIL all_model p=%0d n=%0d: got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", phase, n,
                   sw_stable, sw_rise, sw_fall, evt_pending, evt_any, m_stable, m_rise, m_fall, m_pend, m_any);
        end
        if (n == 6) begin
          vectors++;
          if ((phase == 0 && (sw_rise !== 32'hFFFF_FFFF || sw_fall !== 32'h0)) ||
              (phase == 1 && (sw_fall !== 32'hFFFF_FFFF || sw_rise !== 32'h0))) begin
            miscompares++; $display("FAIL all_edges p=%0d: got rise=%h fall=%h", phase, sw_rise, sw_fall);
          end
        end
        if (phase == 1 || n >= 7) begin
          vectors++;
          if (evt_pending !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL all_pending p=%0d n=%0d: got %h want ffffffff", phase, n, evt_pending);
          end
        end
      end
    end
  endtask

  task automatic test_tick_reset();
    int edge_n;
    bit found;
    found = 1'b0; edge_n = 0;
    raw_t = 32'h80;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (!found && stable_t[7]) begin found = 1'b1; edge_n = n; end
    end
    vectors++;
    if (!found || edge_n < 7 || edge_n > 10) begin
      miscompares++; $display("FAIL tick_latency: got edge %0d (found=%0d) want 7..10", edge_n, found);
    end
    vectors++;
    if (stable_t !== 32'h80 || pend_t !== 32'h80 || any_t !== 1'b1) begin
      miscompares++; $display("FAIL tick_state: got stable=%h pend=%h any=%b want 00000080/00000080/1", stable_t, pend_t, any_t);
    end
    raw_t = 32'h0;
    repeat (4) @(negedge clk);
    vectors++;
    if (stable_t !== 32'h80) begin miscompares++; $display("FAIL tick_mid_hold: got %h want 00000080", stable_t); end
    #2 rst_t = 1'b0;
    #1;
    vectors++;
    if ({stable_t, rise_t, fall_t, pend_t, any_t} !== '0) begin
      miscompares++; $display("FAIL tick_async_reset: got stable=%h pend=%h any=%b want all 0", stable_t, pend_t, any_t);
    end
    @(negedge clk);
    rst_t = 1'b1;
    repeat (12) @(negedge clk);
    vectors++;
    if (stable_t !== 32'h0 || pend_t !== 32'h0) begin
      miscompares++; $display("FAIL tick_after_reset: got stable=%h pend=%h want 0/0", stable_t, pend_t);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      sw_raw  = sw_raw ^ ($urandom & $urandom & $urandom & $urandom);
      evt_clr = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : 32'h0;
      if (n == 300) begin
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({sw_stable, sw_rise, sw_fall, evt_pending, evt_any} !== '0) begin
          miscompares++; $display("FAIL random_async_reset: got stable=%h pend=%h any=%b want all 0", sw_stable, evt_pending, evt_any);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
      vectors++;
      if ({sw_stable, sw_rise, sw_fall, evt_pending, evt_any} !== {m_stable, m_rise, m_fall, m_pend, m_any}) begin
        miscompares++;
        $display("FAIL random_model n=%0d: got %h/%h/%h/%h/%b want %h/%h/%h/%h/%b", n,
                 sw_stable, sw_rise, sw_fall, evt_pending, evt_any, m_stable, m_rise, m_fall, m_pend, m_any);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rst_t = 1'b0; sw_raw = '0; evt_clr = '0; raw_t = '0; clr_t = '0;
    test_reset();
    test_glitch();
    test_fall_bounce();
    test_clear_collision();
    test_all_bits();
    test_tick_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
